pulse_toggle_tx: RTL and testbench



---
 rtl/pulse_toggle_tx.sv | 101 ++++++++++
 tb/tb_pulse_toggle_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_toggle_tx.sv
// ============================================================================
// Module      : pulse_toggle_tx
// Description : Toggle-encoded pulse transmitter with a pending-event queue,
//               minimum flip spacing and optional ack-toggle flow control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_toggle_tx #(
  parameter int CNT_W     = 4,
  parameter int GAP       = 8,
  parameter int HANDSHAKE = 0
) (
  input  logic             clka,
  input  logic             src_rst,
  input  logic             pulse_in,
  input  logic             ack_tog,
  input  logic             clr_ovf,
  output logic             tog_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             ovf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [7:0]       GAP_LOAD = 8'(GAP - 1);
  localparam logic             HS_EN    = (HANDSHAKE != 0);
  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             tog_q, tog_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [1:0]       state_q, state_d;
  logic             ack_s1_q, ack_s2_q;

  logic ready, work, issue, deq, direct, full, accepted, drop;

  always_comb begin
    ready    = (gap_cnt_q == 8'd0) && (!HS_EN || (ack_s2_q == tog_q));
    work     = (pending_q != '0) || pulse_in;
    issue    = ready && work;
    // The queue drains first; a pulse is consumed directly only when it is empty.
    deq      = issue && (pending_q != '0);
    direct   = issue && (pending_q == '0);
    full     = (pending_q == CNT_FULL);
    drop     = pulse_in && full && !deq;
    accepted = pulse_in && !direct && !drop;

    pending_d = pending_q;
    if (accepted && !deq) pending_d = pending_q + CNT_ONE;
    else if (!accepted && deq) pending_d = pending_q - CNT_ONE;

    tog_d = issue ? ~tog_q : tog_q;

    if (issue) gap_cnt_d = GAP_LOAD;
    else if (gap_cnt_q != 8'd0) gap_cnt_d = gap_cnt_q - 8'd1;
    else gap_cnt_d = 8'd0;

    if (drop) ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else ovf_d = ovf_q;

    // ack_s1_q is what ack_s2_q will hold next cycle.
    if (gap_cnt_d != 8'd0) state_d = ST_GAP;
    else if (HS_EN && (ack_s1_q != tog_d)) state_d = ST_ACK;
    else state_d = ST_IDLE;
  end

  always_ff @(posedge clka or posedge src_rst) begin
    if (src_rst) begin
      tog_q     <= 1'b0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      gap_cnt_q <= 8'd0;
      state_q   <= ST_IDLE;
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
    end else begin
      tog_q     <= tog_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      gap_cnt_q <= gap_cnt_d;
      state_q   <= state_d;
      ack_s1_q  <= ack_tog;
      ack_s2_q  <= ack_s1_q;
    end
  end

  assign tog_out = tog_q;
  assign pending = pending_q;
  assign ovf     = ovf_q;
  assign busy    = (state_q != ST_IDLE) || (pending_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_pulse_toggle_tx.sv
// ============================================================================
// Module      : tb_pulse_toggle_tx
// Description : Directed self-checking bench for pulse_toggle_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_toggle_tx;

  logic clk = 1'b0;
  logic rst;
  logic pulse_a, pulse_b, pulse_c, ack_c, clr_a, clr_b, clr_c;
  logic tog_a, tog_b, tog_c, busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c;
  logic [3:0] pend_a, pend_c;
  logic [1:0] pend_b;

  int n_tests = 0;
  int n_fail  = 0;
  int flips_a, flips_b, flips_c;
  logic prev_a, prev_b, prev_c;

  always #5 clk = ~clk;

  pulse_toggle_tx #(.CNT_W(4), .GAP(8), .HANDSHAKE(0)) u_a (
    .clka(clk), .src_rst(rst), .pulse_in(pulse_a), .ack_tog(1'b0), .clr_ovf(clr_a),
    .tog_out(tog_a), .pending(pend_a), .busy(busy_a), .ovf(ovf_a));

  pulse_toggle_tx #(.CNT_W(2), .GAP(8), .HANDSHAKE(0)) u_b (
    .clka(clk), .src_rst(rst), .pulse_in(pulse_b), .ack_tog(1'b0), .clr_ovf(clr_b),
    .tog_out(tog_b), .pending(pend_b), .busy(busy_b), .ovf(ovf_b));

  pulse_toggle_tx #(.CNT_W(4), .GAP(2), .HANDSHAKE(1)) u_c (
    .clka(clk), .src_rst(rst), .pulse_in(pulse_c), .ack_tog(ack_c), .clr_ovf(clr_c),
    .tog_out(tog_c), .pending(pend_c), .busy(busy_c), .ovf(ovf_c));

  // Advance one edge, sample 1 time unit later and count tog_out flips.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tog_a !== prev_a) flips_a++;
    if (tog_b !== prev_b) flips_b++;
    if (tog_c !== prev_c) flips_c++;
    prev_a = tog_a;
    prev_b = tog_b;
    prev_c = tog_c;
  endtask

  task automatic do_reset();
    pulse_a = 0; pulse_b = 0; pulse_c = 0; ack_c = 0;
    clr_a = 0; clr_b = 0; clr_c = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    flips_a = 0; flips_b = 0; flips_c = 0;
    prev_a = tog_a; prev_b = tog_b; prev_c = tog_c;
  endtask

  task automatic test_reset();
    pulse_a = 0; pulse_b = 0; pulse_c = 0; ack_c = 0;
    clr_a = 0; clr_b = 0; clr_c = 0;
    rst = 1'b1;
    #3;
    n_tests++; if (tog_a !== 1'b0 || tog_b !== 1'b0 || tog_c !== 1'b0) begin n_fail++; $display("FAIL reset_tog: got %b%b%b expected 000", tog_a, tog_b, tog_c); end
    n_tests++; if (pend_a !== 4'd0 || pend_b !== 2'd0 || pend_c !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d %0d %0d expected 0 0 0", pend_a, pend_b, pend_c); end
    n_tests++; if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b%b%b expected 000", busy_a, busy_b, busy_c); end
    n_tests++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0 || ovf_c !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b%b%b expected 000", ovf_a, ovf_b, ovf_c); end
    do_reset();
    repeat (3) tick();
    n_tests++; if (tog_a !== 1'b0 || busy_a !== 1'b0 || flips_a != 0) begin n_fail++; $display("FAIL reset_idle: got tog=%b busy=%b flips=%0d expected 0 0 0", tog_a, busy_a, flips_a); end
  endtask

  task automatic test_single();
    do_reset();
    repeat (9) tick();
    pulse_a = 1; tick(); pulse_a = 0;   // edge 10
    n_tests++; if (tog_a !== 1'b1) begin n_fail++; $display("FAIL single_flip: got %b expected 1", tog_a); end
    n_tests++; if (pend_a !== 4'd0) begin n_fail++; $display("FAIL single_pending: got %0d expected 0", pend_a); end
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_e10: got %b expected 1", busy_a); end
    for (int e = 11; e <= 16; e++) begin
      tick();
      n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_e%0d: got %b expected 1", e, busy_a); end
    end
    tick();   // edge 17
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy_e17: got %b expected 0", busy_a); end
    n_tests++; if (flips_a != 1 || tog_a !== 1'b1) begin n_fail++; $display("FAIL single_flips: got flips=%0d tog=%b expected 1 1", flips_a, tog_a); end
  endtask

  task automatic test_burst();
    do_reset();
    repeat (9) tick();
    pulse_a = 1;
    repeat (5) tick();   // edges 10..14
    pulse_a = 0;
    n_tests++; if (pend_a !== 4'd4) begin n_fail++; $display("FAIL burst_pending_e14: got %0d expected 4", pend_a); end
    n_tests++; if (flips_a != 1) begin n_fail++; $display("FAIL burst_flips_e14: got %0d expected 1", flips_a); end
    for (int e = 15; e <= 42; e++) begin
      tick();
      n_tests++; if (flips_a != 1 + (e - 10) / 8) begin n_fail++; $display("FAIL burst_flips_e%0d: got %0d expected %0d", e, flips_a, 1 + (e - 10) / 8); end
      if (e == 18 || e == 26 || e == 34 || e == 42) begin
        n_tests++; if (pend_a !== 4'((42 - e) / 8)) begin n_fail++; $display("FAIL burst_pending_e%0d: got %0d expected %0d", e, pend_a, (42 - e) / 8); end
      end
    end
    n_tests++; if (tog_a !== 1'b1 || ovf_a !== 1'b0) begin n_fail++; $display("FAIL burst_final: got tog=%b ovf=%b expected 1 0", tog_a, ovf_a); end
  endtask

  task automatic test_overflow();
    do_reset();
    pulse_b = 1;
    repeat (4) tick();   // edges 0..3
    n_tests++; if (pend_b !== 2'd3 || ovf_b !== 1'b0) begin n_fail++; $display("FAIL ovf_fill_e3: got pend=%0d ovf=%b expected 3 0", pend_b, ovf_b); end
    tick();   // edge 4, dropped
    n_tests++; if (ovf_b !== 1'b1 || pend_b !== 2'd3) begin n_fail++; $display("FAIL ovf_set_e4: got ovf=%b pend=%0d expected 1 3", ovf_b, pend_b); end
    tick();   // edge 5, dropped
    pulse_b = 0;
    repeat (35) tick();
    n_tests++; if (flips_b != 4) begin n_fail++; $display("FAIL ovf_flips: got %0d expected 4", flips_b); end
    n_tests++; if (tog_b !== 1'b0 || pend_b !== 2'd0 || ovf_b !== 1'b1) begin n_fail++; $display("FAIL ovf_final: got tog=%b pend=%0d ovf=%b expected 0 0 1", tog_b, pend_b, ovf_b); end
  endtask

  task automatic test_handshake();
    do_reset();
    repeat (4) tick();
    pulse_c = 1; tick();   // edge 5
    n_tests++; if (tog_c !== 1'b1) begin n_fail++; $display("FAIL hs_first_flip: got %b expected 1", tog_c); end
    tick(); pulse_c = 0;   // edge 6
    n_tests++; if (pend_c !== 4'd1) begin n_fail++; $display("FAIL hs_pending_e6: got %0d expected 1", pend_c); end
    repeat (13) tick();    // edges 7..19
    n_tests++; if (tog_c !== 1'b1 || pend_c !== 4'd1 || busy_c !== 1'b1) begin n_fail++; $display("FAIL hs_blocked_e19: got tog=%b pend=%0d busy=%b expected 1 1 1", tog_c, pend_c, busy_c); end
    ack_c = 1;
    repeat (2) tick();     // edges 20, 21
    n_tests++; if (tog_c !== 1'b1) begin n_fail++; $display("FAIL hs_early_e21: got %b expected 1", tog_c); end
    tick();                // edge 22
    n_tests++; if (tog_c !== 1'b0 || pend_c !== 4'd0 || flips_c != 2) begin n_fail++; $display("FAIL hs_second_e22: got tog=%b pend=%0d flips=%0d expected 0 0 2", tog_c, pend_c, flips_c); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_b = 1;
    repeat (5) tick();
    pulse_b = 0;
    n_tests++; if (pend_b !== 2'd3 || tog_b !== 1'b1 || ovf_b !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got pend=%0d tog=%b ovf=%b expected 3 1 1", pend_b, tog_b, ovf_b); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (tog_b !== 1'b0 || pend_b !== 2'd0 || ovf_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got tog=%b pend=%0d ovf=%b busy=%b expected 0 0 0 0", tog_b, pend_b, ovf_b, busy_b); end
    @(posedge clk);
    #1 rst = 1'b0;
    prev_b = tog_b; flips_b = 0;
    repeat (30) tick();
    n_tests++; if (flips_b != 0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet: got flips=%0d busy=%b expected 0 0", flips_b, busy_b); end
    pulse_b = 1; tick(); pulse_b = 0;
    n_tests++; if (tog_b !== 1'b1) begin n_fail++; $display("FAIL midrst_newpulse: got %b expected 1", tog_b); end
  endtask

  task automatic test_clr_collision();
    do_reset();
    pulse_b = 1;
    repeat (5) tick();   // edges 0..4
    n_tests++; if (ovf_b !== 1'b1 || pend_b !== 2'd3) begin n_fail++; $display("FAIL clr_pre: got ovf=%b pend=%0d expected 1 3", ovf_b, pend_b); end
    clr_b = 1;
    tick();              // edge 5: drop and clear together
    pulse_b = 0;
    n_tests++; if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL clr_collision: got %b expected 1", ovf_b); end
    tick();              // edge 6: clear alone
    clr_b = 0;
    n_tests++; if (ovf_b !== 1'b0 || pend_b !== 2'd3) begin n_fail++; $display("FAIL clr_alone: got ovf=%b pend=%0d expected 0 3", ovf_b, pend_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_handshake();
    test_reset_mid();
    test_clr_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
